// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong button conditioning block.
// Optional auto-repeat is enabled with PONG_BTN_AUTOREPEAT_EN.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CONFIRM_ON  = 2'd1,
    PRESSED     = 2'd2,
    CONFIRM_OFF = 2'd3
  } btn_state_t;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  localparam int N_BTN_DEF         = 5;
  localparam int DEBOUNCE_DEF      = 250000;
  localparam int REPEAT_DELAY_DEF  = 30;
  localparam int REPEAT_PERIOD_DEF = 6;

endpackage

// File: rtl/pong_btn_cond_if.sv
// Raw button inputs and conditioned strobes between the board pins
// and the game logic.
interface pong_btn_cond_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic             frame_tick;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_frame;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw, frame_tick,
    input  btn_level, btn_press, btn_release,
    input  btn_frame, btn_repeat
  );

  modport slave (
    input  btn_raw, frame_tick,
    output btn_level, btn_press, btn_release,
    output btn_frame, btn_repeat
  );
endinterface

// File: rtl/pong_debounce.sv
// One button channel: synchronizer, debounce FSM, strobes, frame flag.
// Auto-repeat strobes only when PONG_BTN_AUTOREPEAT_EN is defined.
module pong_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk_pix,
  input  logic reset,
  input  logic raw,
  input  logic frame_tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic frame,
  output logic rpt
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_cfg
    $error("pong_debounce: invalid timing parameters");
  end

  logic          s1, s2;
  btn_state_t    st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lvl_nxt;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    unique case (st)
      IDLE: begin
        if (s2) begin
          st_nxt  = CONFIRM_ON;
          cnt_nxt = '0;
        end
      end
      CONFIRM_ON: begin
        if (!s2)                st_nxt  = IDLE;
        else if (cnt == CNT_MAX) st_nxt = PRESSED;
        else                    cnt_nxt = cnt + 1'b1;
      end
      PRESSED: begin
        if (!s2) begin
          st_nxt  = CONFIRM_OFF;
          cnt_nxt = '0;
        end
      end
      CONFIRM_OFF: begin
        if (s2)                  st_nxt  = PRESSED;
        else if (cnt == CNT_MAX) st_nxt  = IDLE;
        else                     cnt_nxt = cnt + 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign lvl_nxt = (st_nxt == PRESSED) || (st_nxt == CONFIRM_OFF);

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      st    <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      frame <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      level <= lvl_nxt;
      press <= lvl_nxt & ~level;
      rel   <= ~lvl_nxt & level;
      // a new press beats a frame tick in the same cycle
      frame <= press | (frame & ~frame_tick);
    end
  end

`ifdef PONG_BTN_AUTOREPEAT_EN
  localparam int FW = $clog2(REPEAT_DELAY + 1);
  localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam logic [FW-1:0] FMAX = FW'(REPEAT_DELAY);
  localparam logic [PW-1:0] PMAX = PW'(REPEAT_PERIOD - 1);

  logic [FW-1:0] fcnt;
  logic [PW-1:0] pcnt;
  logic          rpt_q;

  // fcnt saturates at the delay; pcnt then paces the periodic strobes
  always_ff @(posedge clk_pix) begin
    if (reset || press) begin
      fcnt  <= '0;
      pcnt  <= '0;
      rpt_q <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (frame_tick && st == PRESSED) begin
        if (fcnt != FMAX) begin
          fcnt  <= fcnt + 1'b1;
          rpt_q <= (fcnt == FMAX - 1'b1);
        end else if (pcnt == PMAX) begin
          pcnt  <= '0;
          rpt_q <= 1'b1;
        end else begin
          pcnt  <= pcnt + 1'b1;
        end
      end
    end
  end

  assign rpt = press | rpt_q;
`else
  assign rpt = press;
`endif

endmodule

// File: rtl/pong_btn_cond.sv
// Conditions the five board buttons {C,R,L,D,U} for the game logic.
// Auto-repeat strobes only when PONG_BTN_AUTOREPEAT_EN is defined.
module pong_btn_cond
  import pong_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input logic            clk_pix,
  input logic            reset,
  pong_btn_cond_if.slave btn
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pong_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_db (
      .clk_pix    (clk_pix),
      .reset      (reset),
      .raw        (btn.btn_raw[i]),
      .frame_tick (btn.frame_tick),
      .level      (btn.btn_level[i]),
      .press      (btn.btn_press[i]),
      .rel        (btn.btn_release[i]),
      .frame      (btn.btn_frame[i]),
      .rpt        (btn.btn_repeat[i])
    );
  end

endmodule
